// File: rtl/disp_pkg.sv
// Shared types and helpers for the multiplexed display scanner.
package disp_pkg;

    localparam int unsigned MAX_DIGITS = 32;
    localparam int unsigned IDX_W      = 5;

    // Result of the next-digit search.
    typedef struct packed {
        logic             found;
        logic             wrap;
        logic [IDX_W-1:0] idx;
    } next_sel_t;

    // Ceiling log2, used for counter and index widths.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    // All-ones anode pattern for n digits (every anode off).
    function automatic logic [MAX_DIGITS-1:0] anode_off(input int unsigned n);
        logic [MAX_DIGITS-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i < n) r[IDX_W'(i)] = 1'b1;
        end
        return r;
    endfunction

    // Next enabled index after sel, modulo n; wrap set when the new index is not above sel.
    function automatic next_sel_t next_enabled(input logic [MAX_DIGITS-1:0] mask,
                                               input logic [IDX_W-1:0]      sel,
                                               input int unsigned           n);
        next_sel_t   r;
        int unsigned c;
        r.found = 1'b0;
        r.wrap  = 1'b0;
        r.idx   = sel;
        c       = 0;
        for (int unsigned k = 1; k <= MAX_DIGITS; k++) begin
            if (k <= n && !r.found) begin
                c = (32'(sel) + k) % n;
                if (mask[IDX_W'(c)]) begin
                    r.found = 1'b1;
                    r.idx   = IDX_W'(c);
                    r.wrap  = (IDX_W'(c) <= sel);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot prescaler: counts 0..PRESCALE-1 while enabled, freezes when disabled.
module scan_prescaler #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             i_Clk,
    input  logic             i_Reset_n,
    input  logic             i_En,
    output logic [CNT_W-1:0] o_cnt_nxt_c,
    output logic             o_tc_c
);

    logic [CNT_W-1:0] cnt_q;

    // Terminal count detect and next count value.
    always_comb begin
        o_tc_c      = i_En && (cnt_q == CNT_W'(PRESCALE - 1));
        o_cnt_nxt_c = cnt_q;
        if (o_tc_c) begin
            o_cnt_nxt_c = '0;
        end else if (i_En) begin
            o_cnt_nxt_c = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= o_cnt_nxt_c;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scanner: active-low one-hot anodes, digit index,
// slot tick and frame pulse, with digit masking and slot-start blanking.
// Optional SCAN_BRIGHT_EN adds i_Bright and a 4-bit PWM brightness gate.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter  int unsigned N_DIGITS  = 4,
    parameter  int unsigned PRESCALE  = 50000,
    parameter  int unsigned BLANK_CYC = 16,
    localparam int unsigned SEL_W     = clog2(N_DIGITS)
) (
    input  logic                i_Clk,
    input  logic                i_Reset_n,
    input  logic                i_En,
    input  logic [N_DIGITS-1:0] i_DigitMask,
`ifdef SCAN_BRIGHT_EN
    input  logic [3:0]          i_Bright,
`endif
    output logic [N_DIGITS-1:0] o_Anodos,
    output logic [SEL_W-1:0]    o_Sel,
    output logic                o_Tick,
    output logic                o_Frame
);

    localparam int unsigned CNT_W = clog2(PRESCALE);

    logic [CNT_W-1:0]    cnt_nxt_c;
    logic                tc_c;
    logic [IDX_W-1:0]    sel_q;
    logic [IDX_W-1:0]    sel_nxt_c;
    logic                frame_nxt_c;
    logic                bright_ok_c;
    logic                lit_c;
    logic [N_DIGITS-1:0] anode_nxt_c;
    next_sel_t           ns_c;

    scan_prescaler #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .i_Clk       (i_Clk),
        .i_Reset_n   (i_Reset_n),
        .i_En        (i_En),
        .o_cnt_nxt_c (cnt_nxt_c),
        .o_tc_c      (tc_c)
    );

`ifdef SCAN_BRIGHT_EN
    logic [3:0] pwm_q;
    logic [3:0] pwm_nxt_c;

    // Free-running PWM phase; 4'hF means always on.
    always_comb begin
        pwm_nxt_c   = pwm_q + 4'd1;
        bright_ok_c = (i_Bright == 4'hF) || (pwm_nxt_c < i_Bright);
    end

    // PWM phase register.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            pwm_q <= 4'd0;
        end else begin
            pwm_q <= pwm_nxt_c;
        end
    end
`else
    assign bright_ok_c = 1'b1;
`endif

    // Next digit index, frame flag and anode pattern, aligned with the next count.
    always_comb begin
        ns_c        = next_enabled(MAX_DIGITS'(i_DigitMask), sel_q, N_DIGITS);
        sel_nxt_c   = sel_q;
        frame_nxt_c = 1'b0;
        if (tc_c && ns_c.found) begin
            sel_nxt_c   = ns_c.idx;
            frame_nxt_c = ns_c.wrap;
        end
        lit_c       = i_En && bright_ok_c && (cnt_nxt_c >= CNT_W'(BLANK_CYC));
        anode_nxt_c = N_DIGITS'(anode_off(N_DIGITS));
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (lit_c && (sel_nxt_c == IDX_W'(k)) && i_DigitMask[SEL_W'(k)]) begin
                anode_nxt_c[SEL_W'(N_DIGITS - 1 - k)] = 1'b0;
            end
        end
    end

    // Output and index registers.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            sel_q    <= '0;
            o_Anodos <= N_DIGITS'(anode_off(N_DIGITS));
            o_Tick   <= 1'b0;
            o_Frame  <= 1'b0;
        end else begin
            sel_q    <= sel_nxt_c;
            o_Anodos <= anode_nxt_c;
            o_Tick   <= tc_c;
            o_Frame  <= frame_nxt_c;
        end
    end

    assign o_Sel = sel_q[SEL_W-1:0];

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl (N_DIGITS=4, PRESCALE=8, BLANK_CYC=2).
module tb_display_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] mask;
    logic [3:0] anodos;
    logic [1:0] sel;
    logic       tick;
    logic       frame;
`ifdef SCAN_BRIGHT_EN
    logic [3:0] bright;
    int         lows;
`endif

    int n_cmp;
    int n_bad;

    display_scan_ctrl #(
        .N_DIGITS  (4),
        .PRESCALE  (8),
        .BLANK_CYC (2)
    ) dut (
        .i_Clk       (clk),
        .i_Reset_n   (rst_n),
        .i_En        (en),
        .i_DigitMask (mask),
`ifdef SCAN_BRIGHT_EN
        .i_Bright    (bright),
`endif
        .o_Anodos    (anodos),
        .o_Sel       (sel),
        .o_Tick      (tick),
        .o_Frame     (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_slot(input string tag, input logic [1:0] s, input logic t, input logic f);
        check({tag, "_sel"}, 32'(sel), 32'(s));
        check({tag, "_tick"}, 32'(tick), 32'(t));
        check({tag, "_frame"}, 32'(frame), 32'(f));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b1;
        en    = 1'b1;
        mask  = 4'b1111;
`ifdef SCAN_BRIGHT_EN
        bright = 4'hF;
`endif
        #1 rst_n = 1'b0;
        #2;
        check("rst_anode", 32'(anodos), 32'hF);
        chk_slot("rst", 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full mask scan 0,1,2,3,0
        check("t1_blank0", 32'(anodos), 32'hF);
        step(2); check("t1_d0", 32'(anodos), 32'h7);
        step(5); check("t1_d0_end", 32'(anodos), 32'h7); check("t1_notick", 32'(tick), 32'h0);
        step(1); chk_slot("t1_s1", 2'd1, 1'b1, 1'b0); check("t1_blank1", 32'(anodos), 32'hF);
        step(2); check("t1_d1", 32'(anodos), 32'hB);
        step(6); chk_slot("t1_s2", 2'd2, 1'b1, 1'b0);
        step(1); check("t1_tick_low", 32'(tick), 32'h0); check("t1_blank2", 32'(anodos), 32'hF);
        step(1); check("t1_d2", 32'(anodos), 32'hD);
        step(6); chk_slot("t1_s3", 2'd3, 1'b1, 1'b0);
        step(2); check("t1_d3", 32'(anodos), 32'hE);
        step(6); chk_slot("t1_wrap", 2'd0, 1'b1, 1'b1);

        // Sparse mask 1010
        mask = 4'b1010;
        step(2); check("t2_masked0", 32'(anodos), 32'hF);
        step(6); chk_slot("t2_s1", 2'd1, 1'b1, 1'b0);
        step(2); check("t2_d1", 32'(anodos), 32'hB);
        step(6); chk_slot("t2_s3", 2'd3, 1'b1, 1'b0);
        step(2); check("t2_d3", 32'(anodos), 32'hE);
        step(6); chk_slot("t2_wrap", 2'd1, 1'b1, 1'b1);

        // Clear the current digit's mask mid-slot
        step(3); check("mc_on", 32'(anodos), 32'hB);
        mask = 4'b1000;
        step(1); check("mc_off", 32'(anodos), 32'hF);
        step(4); chk_slot("mc_skip", 2'd3, 1'b1, 1'b0);
        step(2); check("mc_d3", 32'(anodos), 32'hE);
        step(6); chk_slot("mc_single", 2'd3, 1'b1, 1'b1);

        // All-zero mask
        mask = 4'b0000;
        step(2); check("t3_anode", 32'(anodos), 32'hF);
        step(6); chk_slot("t3_hold", 2'd3, 1'b1, 1'b0);
        step(1); check("t3_ticklow", 32'(tick), 32'h0);
        step(7); chk_slot("t3_hold2", 2'd3, 1'b1, 1'b0);

        // Enable low at cnt=4 for 5 cycles
        mask = 4'b1111;
        step(4); check("t4_on", 32'(anodos), 32'hE);
        en = 1'b0;
        step(1); check("t4_off", 32'(anodos), 32'hF);
        step(4); chk_slot("t4_frozen", 2'd3, 1'b0, 1'b0); check("t4_off2", 32'(anodos), 32'hF);
        en = 1'b1;
        step(1); check("t4_resume", 32'(anodos), 32'hE); check("t4_notick", 32'(tick), 32'h0);
        step(2); check("t4_notick2", 32'(tick), 32'h0);
        step(1); chk_slot("t4_wrap", 2'd0, 1'b1, 1'b1);

        // Asynchronous reset at cnt=5, sel=2
        step(8); step(8); step(5);
        check("t5_pre", 32'(anodos), 32'hD); check("t5_pre_sel", 32'(sel), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("t5_anode", 32'(anodos), 32'hF);
        chk_slot("t5_rst", 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(2); check("t5_d0", 32'(anodos), 32'h7);
        step(6); chk_slot("t5_s1", 2'd1, 1'b1, 1'b0);

        // Mask change coincident with terminal count
        step(7);
        mask = 4'b0001;
        step(1); chk_slot("tcmask", 2'd0, 1'b1, 1'b1);
        step(2); check("tcmask_d0", 32'(anodos), 32'h7);

`ifdef SCAN_BRIGHT_EN
        // Brightness: low cycles per 16 after a fresh reset (pwm and cnt in phase)
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        mask   = 4'b1111;
        bright = 4'd4;
        lows = 0;
        for (int i = 0; i < 16; i++) begin step(1); if (anodos != 4'hF) lows++; end
        check("br4", 32'(lows), 32'd2);
        bright = 4'd10;
        lows = 0;
        for (int i = 0; i < 16; i++) begin step(1); if (anodos != 4'hF) lows++; end
        check("br10", 32'(lows), 32'd6);
        bright = 4'd0;
        lows = 0;
        for (int i = 0; i < 16; i++) begin step(1); if (anodos != 4'hF) lows++; end
        check("br0", 32'(lows), 32'd0);
        bright = 4'hF;
        lows = 0;
        for (int i = 0; i < 16; i++) begin step(1); if (anodos != 4'hF) lows++; end
        check("br15", 32'(lows), 32'd12);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
